// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an internal baud divider and a small
// transmit FIFO. Queued frames go out back-to-back with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state and makes
// parity_mode functional; when undefined parity_mode is ignored).
module uart_tx_fifo #(
  parameter int CLK_DIV    = 1250,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    parity_mode,
  output logic                          tx,
  output logic                          busy,
  output logic                          txdone,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam int NW = $clog2(DATA_BITS) + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [NW-1:0]          bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   txdone_q, txdone_d;
  logic                   push, pop, bit_end;
  logic [DATA_BITS-1:0]   head;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d, par_bit_q, par_bit_d;
`else
  logic unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  assign in_ready   = (count_q < DEPTH_C);
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign bit_end    = (baud_q == BAUD_LAST);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign txdone     = txdone_q;
  assign fifo_count = count_q;

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencing: next state, line value and frame loading on pop
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    txdone_d = 1'b0;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            stop_d  = 1'b0;
            tx_d    = 1'b1;
            state_d = S_STOP;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              tx_d    = par_bit_q;
              state_d = S_PARITY;
            end
`endif
          end else begin
            bit_d = bit_q + NW'(1);
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            txdone_d = 1'b1;
            // A waiting word starts its start bit on this same edge
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      shift_d = head;
      baud_d  = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      state_d = S_START;
`ifdef UART_TX_PARITY_EN
      par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d = (parity_mode == 2'b01) ? ^head : ~^head;
`endif
    end
  end

  // State registers with asynchronous flush of the line, FIFO and frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      txdone_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      txdone_q <= txdone_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: scoreboard of queued words checked cycle by cycle
// against the serial line, plus a second instance with 5 data / 2 stop bits.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] parity_mode = 2'b00;
  logic       tx, busy, txdone;
  logic [2:0] fifo_count;

  logic [4:0] in_data2 = '0;
  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic [1:0] parity_mode2 = 2'b00;
  logic       tx2, busy2, txdone2;
  logic [1:0] fifo_count2;

  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .parity_mode(parity_mode), .tx(tx), .busy(busy),
    .txdone(txdone), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .parity_mode(parity_mode2), .tx(tx2), .busy(busy2),
    .txdone(txdone2), .fifo_count(fifo_count2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] pm;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   start_q[$];
  int   tests = 0;
  int   fails = 0;

  // Monitor state
  int   cyc = 0;
  int   done_exp = -1;
  bit   mon_act = 1'b0;
  int   mon_cnt, mon_fl, bit_err;
  exp_t cur;
  logic fbits [0:10];
  logic [7:0] rx;

  function automatic logic par_on(input logic [1:0] pm);
    return PAR_BUILD && ((pm == 2'b01) || (pm == 2'b10));
  endfunction

  // Line monitor: every cycle of each frame is compared with the frame
  // built from the scoreboard head; txdone must follow the last cycle.
  initial begin
    int p;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mon_act  = 1'b0;
        done_exp = -1;
      end else begin
        if (txdone === 1'b1 || cyc == done_exp) begin
          tests++;
          if (!(txdone === 1'b1 && cyc == done_exp)) begin
            fails++;
            $display("FAIL txdone_timing: txdone=%b at cycle %0d, required 1 at cycle %0d",
                     txdone, cyc, done_exp);
          end
          done_exp = -1;
        end
        if (!mon_act && tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
          end else begin
            cur = exp_q.pop_front();
            fbits[0] = 1'b0;
            for (int i = 0; i < 8; i++) fbits[i+1] = cur.d[i];
            if (par_on(cur.pm)) begin
              fbits[9]  = (cur.pm == 2'b01) ? ^cur.d : ~^cur.d;
              fbits[10] = 1'b1;
              mon_fl    = 11 * DIV;
            end else begin
              fbits[9]  = 1'b1;
              fbits[10] = 1'b1;
              mon_fl    = 10 * DIV;
            end
            mon_act = 1'b1;
            mon_cnt = 0;
            bit_err = 0;
            rx      = '0;
            start_q.push_back(cyc);
          end
        end
        if (mon_act) begin
          p = mon_cnt / DIV;
          if (tx !== fbits[p]) bit_err++;
          if ((mon_cnt % DIV) == 2 && p >= 1 && p <= 8) rx[p-1] = tx;
          mon_cnt++;
          if (mon_cnt == mon_fl) begin
            tests++;
            if (bit_err != 0) begin
              fails++;
              $display("FAIL frame: got data %h with %0d bad line cycles, required data %h pm %b",
                       rx, bit_err, cur.d, cur.pm);
            end
            mon_act  = 1'b0;
            done_exp = cyc + 1;
          end
        end
      end
    end
  end

  // Offer one word (called at a negedge); enqueued at the accepting edge.
  task automatic push(input logic [7:0] d, input logic [1:0] pm);
    int unsigned n = 0;
    in_data     = d;
    parity_mode = pm;
    in_valid    = 1'b1;
    while (in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end else begin
      exp_q.push_back({pm, d});
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || mon_act || busy !== 1'b0 || done_exp >= 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s_drain: %0d words pending busy=%b, required 0 pending and idle",
               name, exp_q.size(), busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || txdone !== 1'b0 || fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL reset_values: tx=%b in_ready=%b busy=%b txdone=%b count=%0d, required 1 1 0 0 0",
               tx, in_ready, busy, txdone, fifo_count);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    push(8'hA5, 2'b00);
    in_valid = 1'b0;
    tests++;
    if (fifo_count !== 3'd1 || tx !== 1'b1) begin
      fails++;
      $display("FAIL single_accept: count=%0d tx=%b, required 1 1", fifo_count, tx);
    end
    @(negedge clk);
    tests++;
    if (tx !== 1'b0 || busy !== 1'b1 || fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL single_pop: tx=%b busy=%b count=%0d, required 0 1 0", tx, busy, fifo_count);
    end
    wait_idle("single");
  endtask

  task automatic test_back_to_back();
    start_q.delete();
    push(8'h00, 2'b00);
    push(8'hFF, 2'b00);
    push(8'h55, 2'b00);
    in_valid = 1'b0;
    wait_idle("b2b");
    tests++;
    if (start_q.size() != 3) begin
      fails++;
      $display("FAIL b2b_frames: got %0d frames, required 3", start_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (start_q[i+1] - start_q[i] != 10 * DIV) begin
          fails++;
          $display("FAIL b2b_gap: start spacing %0d, required %0d",
                   start_q[i+1] - start_q[i], 10 * DIV);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    int unsigned bad = 0;
    push(8'h11, 2'b00);
    push(8'h22, 2'b00);
    push(8'h33, 2'b00);
    push(8'h44, 2'b00);
    push(8'h55, 2'b00);
    tests++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: count=%0d in_ready=%b, required 4 0", fifo_count, in_ready);
    end
    in_data = 8'h99;
    for (int i = 0; i < 8; i++) begin
      if (in_ready !== 1'b0 || fifo_count !== 3'd4) bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL full_hold: %0d cycles with count!=4 or in_ready high, required 0", bad);
    end
    wait_idle("full");
  endtask

  task automatic test_parity();
    push(8'h07, 2'b01);
    in_valid = 1'b0;
    @(negedge clk);
    push(8'h07, 2'b10);
    in_valid = 1'b0;
    parity_mode = 2'b00;
    wait_idle("parity");
  endtask

  task automatic test_two_stop();
    int unsigned n = 0;
    int unsigned bad = 0;
    in_data2  = 5'h1F;
    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    while (tx2 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 1) begin
      fails++;
      $display("FAIL stop2_latency: start bit after %0d cycles, required 1", n);
    end
    for (int i = 0; i < 32; i++) begin
      if (tx2 !== ((i < DIV) ? 1'b0 : 1'b1) || txdone2 !== 1'b0 || busy2 !== 1'b1) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stop2_line: %0d bad cycles in 32-cycle frame, required 0", bad);
    end
    tests++;
    if (txdone2 !== 1'b1 || busy2 !== 1'b0) begin
      fails++;
      $display("FAIL stop2_done: txdone=%b busy=%b at cycle 32, required 1 0", txdone2, busy2);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int unsigned bad = 0;
    push(8'hC3, 2'b00);
    push(8'h81, 2'b00);
    in_valid = 1'b0;
    repeat (17) @(negedge clk);
    tests++;
    if (tx !== 1'b0) begin
      fails++;
      $display("FAIL mid_bit3: tx=%b, required 0", tx);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || txdone !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: tx=%b count=%0d busy=%b txdone=%b, required 1 0 0 0",
               tx, fifo_count, busy, txdone);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || txdone !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mid_after: %0d cycles with activity after reset, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    if (PAR_BUILD) test_parity();
    test_two_stop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
